burst_capture_arbiter: RTL and testbench
========================================

# burst_capture_arbiter

Shares one 8-entry × 16-bit capture buffer between two burst producers. When a producer requests, the block grants it, captures exactly `CYCLES` consecutive words, then drains them to a single consumer over a valid/ready port. It sits between the producer channels and the downstream consumer, and sequences the buffer so that only one burst occupies it at a time.

## Interface
- `CYCLES`, 8: words per burst; legal range 1..8.
- `WIDTH`, 16: data word width.

- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req` in 2: burst request, bit i from producer i; level-sensitive.
- `data0` in WIDTH: producer 0 data.
- `data1` in WIDTH: producer 1 data.
- `grant` out 2: one-hot, registered; held for the whole capture.
- `busy` out 1: high in CAPTURE or DRAIN.
- `rd_valid` out 1: buffer word available.
- `rd_data` out WIDTH: `buffer[rd_ptr]`.
- `rd_last` out 1: current read word is the last of the burst.
- `rd_ready` in 1: consumer accepts the word.
- `done` out 1: single-cycle pulse after the last word is accepted.

## Operation
- The FSM has three states: IDLE, CAPTURE and DRAIN. Reset enters IDLE.
- **IDLE**
  - If `req != 0`, select a winner, register `grant`, clear `wr_ptr` and go to CAPTURE.
  - Otherwise stay in IDLE.
- **CAPTURE**
  - Every rising edge writes the granted producer's data to `buffer[wr_ptr]` and increments `wr_ptr`.
  - When `wr_ptr == CYCLES-1` is written, clear `grant`, clear `rd_ptr` and go to DRAIN.
  - `req` is not sampled in CAPTURE. Dropping or raising any `req` mid-burst has no effect, and the burst always completes.
- **DRAIN**
  - `rd_valid = 1` and `rd_data = buffer[rd_ptr]`.
  - `rd_last = (rd_ptr == CYCLES-1)`.
  - When `rd_valid & rd_ready`, increment `rd_ptr`.
  - On the last accepted word, pulse `done`, deassert `rd_valid` and go to IDLE.
  - While `rd_ready` is low, all read outputs hold stable.
- **Pointers:** `wr_ptr` and `rd_ptr` are 3 bits wide and never wrap within a burst. Both are cleared on every state entry that uses them.
- **Arbitration:** the winner is chosen only in IDLE. If exactly one `req` is set, it wins. A tie is resolved as described under Configuration. `last_grant` updates to the winner when the grant is issued.
- **Illegal parameter:** `CYCLES` outside 1..8 fails elaboration through a generate-time `$error`.

## Timing
- **Reset values:**
  - Outputs: `grant = 0`, `busy = 0`, `rd_valid = 0`, `rd_last = 0`, `done = 0`, `rd_data = 0`.
  - Internal: both pointers = 0, `last_grant` = producer 1, so producer 0 wins the first tie.
  - Buffer contents are not reset.
- **Grant and capture:**
  - `req` seen at edge T raises `grant` and `busy` after edge T.
  - The producer drives word k (k = 0..CYCLES-1) during the k-th grant cycle. It is sampled at edges T+1..T+CYCLES.
  - Capture takes exactly `CYCLES` cycles; there is no backpressure on producers.
- **Drain:**
  - `rd_valid` rises after edge T+CYCLES.
  - With `rd_ready` held high, the burst drains in `CYCLES` cycles.
  - `done` is high for the cycle after the last acceptance, coincident with IDLE.
- **Back-to-back bursts:**
  - A request pending during `done` is granted at the edge that ends the `done` cycle.
  - There is one idle cycle between bursts.
- **Reset mid-operation:** asserting `reset_n` low at any point immediately returns the block to IDLE with the reset output values. A partial burst is discarded, and no `done` is issued for it.

## Configuration
- The macro is `BURST_ARB_ROUND_ROBIN_EN`.
- **Defined:** on a tie (`req == 2'b11`), the producer not equal to `last_grant` wins. Two producers that keep requesting therefore alternate.
- **Undefined:** fixed priority, so producer 0 always wins a tie. `last_grant` is neither implemented nor used.

## Test plan
- **Single burst:** reset, then `req = 01` with `data0 = 0x1000+k` for k = 0..7, and `rd_ready = 1`. Expect `grant = 01` for 8 cycles, then `rd_data` 0x1000..0x1007 on consecutive cycles, `rd_last` on 0x1007, and `done` one cycle later.
- **Backpressure:** producer 1 burst, with `rd_ready` toggling 1,0,0,1… Expect every word delivered exactly once and in order. `rd_data` and `rd_last` must stay stable while `rd_ready = 0`.
- **Tie arbitration:** `req = 11` held for 3 bursts.
  - With the macro defined: grant order 01, 10, 01.
  - Without it: grant order 01, 01, 01.
- **Mid-capture request change:** `req = 01`, then drop `req[0]` and raise `req[1]` at capture cycle 3. Expect the burst to complete with 8 words from producer 0, then producer 1 granted one cycle after `done`.
- **Short burst:** `CYCLES = 1`. Expect a one-cycle grant, a single read word with `rd_last = 1`, and a `done` pulse.
- **Reset mid-drain:** pull `reset_n` low after 3 words are read. Expect all outputs to go to 0 immediately and no `done`. After release, a new `req = 10` captures normally.

Source files
------------

// File: rtl/burst_capture_arbiter.sv
// Two-producer burst capture arbiter: grants one producer, captures CYCLES words
// into an 8-deep buffer, then drains them over valid/ready. Tie policy: BURST_ARB_ROUND_ROBIN_EN.
module burst_capture_arbiter #(
  parameter int CYCLES = 8,
  parameter int WIDTH  = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] data0,
  input  logic [WIDTH-1:0] data1,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last,
  input  logic             rd_ready,
  output logic             done
);

  // state   | meaning
  // IDLE    | waiting for any request; arbitration happens here only
  // CAPTURE | writing the granted producer's words, one per cycle
  // DRAIN   | presenting buffered words to the consumer
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  if (CYCLES < 1 || CYCLES > 8) begin : g_cycles_check
    $error("burst_capture_arbiter: CYCLES must be within 1..8");
  end

  localparam logic [2:0] PTR_LAST = 3'(CYCLES - 1);

  state_t           state, state_d;
  logic [2:0]       wr_ptr, wr_ptr_d;
  logic [2:0]       rd_ptr, rd_ptr_d;
  logic [1:0]       grant_d;
  logic             done_d;
  logic             winner;
  logic [WIDTH-1:0] buffer [8];

`ifdef BURST_ARB_ROUND_ROBIN_EN
  logic last_grant, last_grant_d;
`endif

  always_comb begin
    winner = 1'b0;
    if (req == 2'b10) begin
      winner = 1'b1;
    end else if (req == 2'b11) begin
`ifdef BURST_ARB_ROUND_ROBIN_EN
      winner = ~last_grant;
`else
      winner = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    wr_ptr_d = wr_ptr;
    rd_ptr_d = rd_ptr;
    done_d   = 1'b0;
`ifdef BURST_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant;
`endif
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          grant_d  = winner ? 2'b10 : 2'b01;
          wr_ptr_d = 3'd0;
          state_d  = CAPTURE;
`ifdef BURST_ARB_ROUND_ROBIN_EN
          last_grant_d = winner;
`endif
        end
      end
      CAPTURE: begin
        if (wr_ptr == PTR_LAST) begin
          grant_d  = 2'b00;
          rd_ptr_d = 3'd0;
          state_d  = DRAIN;
        end else begin
          wr_ptr_d = wr_ptr + 3'd1;
        end
      end
      DRAIN: begin
        if (rd_ready) begin
          if (rd_ptr == PTR_LAST) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            rd_ptr_d = rd_ptr + 3'd1;
          end
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      grant  <= 2'b00;
      wr_ptr <= 3'd0;
      rd_ptr <= 3'd0;
      done   <= 1'b0;
`ifdef BURST_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      state  <= state_d;
      grant  <= grant_d;
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      done   <= done_d;
`ifdef BURST_ARB_ROUND_ROBIN_EN
      last_grant <= last_grant_d;
`endif
    end
  end

  // Buffer is storage only; it is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (state == CAPTURE) begin
      buffer[wr_ptr] <= grant[1] ? data1 : data0;
    end
  end

  assign busy     = (state != IDLE);
  assign rd_valid = (state == DRAIN);
  // Gated so stale buffer contents never leak out while idle or in reset.
  assign rd_data  = rd_valid ? buffer[rd_ptr] : '0;
  assign rd_last  = rd_valid && (rd_ptr == PTR_LAST);

endmodule

// File: tb/tb_burst_capture_arbiter.sv
// Randomized self-checking bench for burst_capture_arbiter; reference model tracks
// expected winners and the words each producer drove during its grant.
module tb_burst_capture_arbiter;
  localparam int CYCLES = 8;
  localparam int WIDTH  = 16;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       req = 2'b00;
  logic [WIDTH-1:0] data0 = '0, data1 = '0;
  logic [1:0]       grant;
  logic             busy, rd_valid, rd_last, done;
  logic [WIDTH-1:0] rd_data;
  logic             rd_ready = 1'b0;

  logic [1:0]       s_req = 2'b00;
  logic [WIDTH-1:0] s_data0 = '0, s_data1 = '0;
  logic [1:0]       s_grant;
  logic             s_busy, s_rd_valid, s_rd_last, s_done;
  logic [WIDTH-1:0] s_rd_data;
  logic             s_ready = 1'b0;

  int   n_checks = 0;
  int   n_pass = 0;
  logic model_last = 1'b1;

  always #5 clock = ~clock;

  burst_capture_arbiter #(.CYCLES(CYCLES), .WIDTH(WIDTH)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .data0(data0), .data1(data1),
    .grant(grant), .busy(busy), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last), .rd_ready(rd_ready), .done(done));

  burst_capture_arbiter #(.CYCLES(1), .WIDTH(WIDTH)) dut_short (
    .clock(clock), .reset_n(reset_n), .req(s_req), .data0(s_data0), .data1(s_data1),
    .grant(s_grant), .busy(s_busy), .rd_valid(s_rd_valid), .rd_data(s_rd_data),
    .rd_last(s_rd_last), .rd_ready(s_ready), .done(s_done));

  function automatic logic [1:0] expect_grant(input logic [1:0] r);
    if (r == 2'b01) return 2'b01;
    if (r == 2'b10) return 2'b10;
`ifdef BURST_ARB_ROUND_ROBIN_EN
    return model_last ? 2'b01 : 2'b10;
`else
    return 2'b01;
`endif
  endfunction

  // ready_mode: 0 = always ready, 1 = pattern 1,0,0, 2 = random; abort_after >= 0 resets mid-drain
  task automatic run_burst(input logic [1:0] req_start, input logic [1:0] req_after,
                           input bit seq_data, input int ready_mode, input int abort_after);
    logic [1:0]       eg;
    logic [WIDTH-1:0] words[$];
    logic [WIDTH-1:0] w;
    logic             r;
    int               idx, cyc, change_at;
    change_at = (CYCLES > 3) ? 3 : CYCLES - 1;
    req = req_start;
    eg = expect_grant(req_start);
    model_last = eg[1];
    @(posedge clock); #1;
    n_checks++; if (grant !== eg) $display("FAIL grant_issue: got %b exp %b", grant, eg); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL busy_capture: got %b exp 1", busy); else n_pass++;
    for (int k = 0; k < CYCLES; k++) begin
      if (k > 0) begin
        @(posedge clock); #1;
        n_checks++; if (grant !== eg) $display("FAIL grant_hold k=%0d: got %b exp %b", k, grant, eg); else n_pass++;
      end
      if (k == change_at) req = req_after;
      w = seq_data ? WIDTH'(16'h1000 + k) : WIDTH'($urandom);
      if (eg == 2'b01) begin data0 = w; data1 = WIDTH'($urandom); end
      else             begin data1 = w; data0 = WIDTH'($urandom); end
      words.push_back(w);
    end
    @(posedge clock); #1;
    n_checks++; if (grant !== 2'b00) $display("FAIL grant_clear: got %b exp 00", grant); else n_pass++;
    idx = 0; cyc = 0;
    while (idx < CYCLES && cyc < 200) begin
      if (abort_after >= 0 && idx == abort_after) begin
        reset_n = 1'b0; #1;
        n_checks++; if ({grant, busy, rd_valid, rd_last, done} !== 6'b0)
          $display("FAIL reset_outputs: got g=%b b=%b v=%b l=%b d=%b exp 0", grant, busy, rd_valid, rd_last, done); else n_pass++;
        n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h exp 0", rd_data); else n_pass++;
        model_last = 1'b1;
        rd_ready = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL no_done_after_reset: got d=%b b=%b exp 0 0", done, busy); else n_pass++;
        return;
      end
      case (ready_mode)
        0: r = 1'b1;
        1: r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      rd_ready = r;
      n_checks++; if (rd_valid !== 1'b1) $display("FAIL rd_valid idx=%0d: got %b exp 1", idx, rd_valid); else n_pass++;
      n_checks++; if (rd_data !== words[idx]) $display("FAIL rd_data idx=%0d: got %h exp %h", idx, rd_data, words[idx]); else n_pass++;
      n_checks++; if (rd_last !== (idx == CYCLES - 1)) $display("FAIL rd_last idx=%0d: got %b exp %b", idx, rd_last, idx == CYCLES - 1); else n_pass++;
      @(posedge clock); #1;
      if (r) idx++;
      cyc++;
    end
    rd_ready = 1'b0;
    n_checks++; if (idx != CYCLES) $display("FAIL drain_timeout: got %0d words exp %0d", idx, CYCLES); else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL done_pulse: got %b exp 1", done); else n_pass++;
    n_checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) $display("FAIL after_drain: got v=%b b=%b exp 0 0", rd_valid, busy); else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    n_checks++; if ({grant, busy, rd_valid, rd_last, done} !== 6'b0)
      $display("FAIL reset_state: got g=%b b=%b v=%b l=%b d=%b exp 0", grant, busy, rd_valid, rd_last, done); else n_pass++;
    n_checks++; if (rd_data !== '0) $display("FAIL reset_rd_data: got %h exp 0", rd_data); else n_pass++;
    n_checks++; if (s_rd_valid !== 1'b0 || s_grant !== 2'b00) $display("FAIL reset_short: got v=%b g=%b exp 0 00", s_rd_valid, s_grant); else n_pass++;
    model_last = 1'b1;
    @(negedge clock); reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_single_burst();
    run_burst(2'b01, 2'b01, 1'b1, 0, -1);
    req = 2'b00;
    @(posedge clock); #1;
    n_checks++; if (done !== 1'b0) $display("FAIL done_single_cycle: got %b exp 0", done); else n_pass++;
    n_checks++; if (grant !== 2'b00) $display("FAIL idle_after_done: got %b exp 00", grant); else n_pass++;
  endtask

  task automatic test_backpressure();
    run_burst(2'b10, 2'b00, 1'b0, 1, -1);
    @(posedge clock); #1;
  endtask

  task automatic test_mid_capture_change();
    run_burst(2'b01, 2'b10, 1'b0, 0, -1);
    run_burst(2'b10, 2'b00, 1'b0, 0, -1);
    @(posedge clock); #1;
  endtask

  task automatic test_tie();
    run_burst(2'b11, 2'b11, 1'b0, 0, -1);
    run_burst(2'b11, 2'b11, 1'b0, 2, -1);
    run_burst(2'b11, 2'b00, 1'b0, 0, -1);
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    logic [1:0] rs, ra;
    rs = 2'($urandom_range(1, 3));
    for (int b = 0; b < 6; b++) begin
      ra = (b == 5) ? 2'b00 : 2'($urandom_range(0, 3));
      run_burst(rs, ra, 1'b0, 2, -1);
      if (ra == 2'b00) begin
        @(posedge clock); #1;
        rs = 2'($urandom_range(1, 3));
      end else begin
        rs = ra;
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    run_burst(2'b01, 2'b00, 1'b0, 0, 3);
    run_burst(2'b10, 2'b00, 1'b0, 0, -1);
    @(posedge clock); #1;
  endtask

  task automatic test_short_burst();
    logic [WIDTH-1:0] w;
    s_req = 2'b01;
    @(posedge clock); #1;
    n_checks++; if (s_grant !== 2'b01 || s_busy !== 1'b1) $display("FAIL short_grant: got g=%b b=%b exp 01 1", s_grant, s_busy); else n_pass++;
    s_req = 2'b00;
    w = WIDTH'($urandom);
    s_data0 = w; s_data1 = ~w;
    @(posedge clock); #1;
    n_checks++; if (s_grant !== 2'b00) $display("FAIL short_grant_clear: got %b exp 00", s_grant); else n_pass++;
    n_checks++; if (s_rd_valid !== 1'b1 || s_rd_data !== w) $display("FAIL short_word: got v=%b %h exp 1 %h", s_rd_valid, s_rd_data, w); else n_pass++;
    n_checks++; if (s_rd_last !== 1'b1) $display("FAIL short_last: got %b exp 1", s_rd_last); else n_pass++;
    s_ready = 1'b1;
    @(posedge clock); #1;
    s_ready = 1'b0;
    n_checks++; if (s_done !== 1'b1 || s_rd_valid !== 1'b0) $display("FAIL short_done: got d=%b v=%b exp 1 0", s_done, s_rd_valid); else n_pass++;
    @(posedge clock); #1;
    n_checks++; if (s_done !== 1'b0) $display("FAIL short_done_pulse: got %b exp 0", s_done); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_backpressure();
    test_mid_capture_change();
    test_tie();
    test_random();
    test_reset_mid_drain();
    test_short_burst();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
